// File: rtl/cla_16bits_pkg.sv
// Shared width constants for the 16-bit two-level carry-lookahead adder.
package cla_16bits_pkg;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned GRP_W  = 4;
  localparam int unsigned GRP_N  = 4;
endpackage

// File: rtl/cla_16bits_cla_4bits.sv
// 4-bit lookahead block: internal carries from local g/p, plus group generate/propagate.
module cla_4bits
  import cla_16bits_pkg::*;
(
  input  logic [GRP_W-1:0] a,
  input  logic [GRP_W-1:0] b,
  input  logic             ci,
  output logic [GRP_W-1:0] s,
  output logic             G,
  output logic             P
);

  logic [GRP_W-1:0] w_g;
  logic [GRP_W-1:0] w_p;
  logic [GRP_W-1:0] w_c;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // Every carry is a flat sum of products of ci and the lower g/p; no ripple.
  assign w_c[0] = ci;
  assign w_c[1] = w_g[0] | (w_p[0] & ci);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & ci);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & ci);

  assign G = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
           | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
  assign P = &w_p;

  assign s = w_p ^ w_c;

endmodule

// File: rtl/cla_16bits.sv
// Registered 16-bit adder: four cla_4bits groups joined by a second-level lookahead unit.
module cla_16bits
  import cla_16bits_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] A_i,
  input  logic [DATA_W-1:0] B_i,
  input  logic              Ci_i,
  output logic [DATA_W-1:0] S_o,
  output logic              Co_o
);

  logic [GRP_N-1:0]  w_G;
  logic [GRP_N-1:0]  w_P;
  logic [GRP_N-1:0]  w_gci;
  logic [DATA_W-1:0] w_sum;
  logic              w_c4, w_c8, w_c12, w_c16;

  logic [DATA_W-1:0] r_s;
  logic              r_co;

  for (genvar k = 0; k < GRP_N; k++) begin : g_grp
    cla_4bits u_grp (
      .a  (A_i[k*GRP_W +: GRP_W]),
      .b  (B_i[k*GRP_W +: GRP_W]),
      .ci (w_gci[k]),
      .s  (w_sum[k*GRP_W +: GRP_W]),
      .G  (w_G[k]),
      .P  (w_P[k])
    );
  end

  assign w_c4  = w_G[0] | (w_P[0] & Ci_i);
  assign w_c8  = w_G[1] | (w_P[1] & w_G[0]) | (w_P[1] & w_P[0] & Ci_i);
  assign w_c12 = w_G[2] | (w_P[2] & w_G[1]) | (w_P[2] & w_P[1] & w_G[0])
               | (w_P[2] & w_P[1] & w_P[0] & Ci_i);
  assign w_c16 = w_G[3] | (w_P[3] & w_G[2]) | (w_P[3] & w_P[2] & w_G[1])
               | (w_P[3] & w_P[2] & w_P[1] & w_G[0])
               | (w_P[3] & w_P[2] & w_P[1] & w_P[0] & Ci_i);

  assign w_gci = {w_c12, w_c8, w_c4, Ci_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s  <= '0;
      r_co <= 1'b0;
    end else begin
      r_s  <= w_sum;
      r_co <= w_c16;
    end
  end

  assign S_o  = r_s;
  assign Co_o = r_co;

endmodule

// File: tb/tb_cla_16bits.sv
// Directed and random checks of cla_16bits against a 17-bit '+' reference, one cycle latency.
module tb_cla_16bits;

  logic        clk;
  logic        rst;
  logic [15:0] a;
  logic [15:0] b;
  logic        ci;
  logic [15:0] s;
  logic        co;

  int unsigned checks = 0;
  int unsigned errors = 0;

  cla_16bits dut (
    .clk_i (clk),
    .rst_i (rst),
    .A_i   (a),
    .B_i   (b),
    .Ci_i  (ci),
    .S_o   (s),
    .Co_o  (co)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [16:0] exp);
    logic [16:0] obs;
    obs = {co, s};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed Co=%b S=%h, expected Co=%b S=%h",
             tag, obs[16], obs[15:0], exp[16], exp[15:0]);
    end
  endtask

  // Drive one vector before a rising edge, then check the registered result just after it.
  task automatic step(input string tag, input logic r, input logic [15:0] va,
                      input logic [15:0] vb, input logic vc, input logic [16:0] exp);
    @(negedge clk);
    rst = r; a = va; b = vb; ci = vc;
    @(posedge clk);
    #1;
    check(tag, exp);
  endtask

  function automatic logic [16:0] ref_add(input logic [15:0] va, input logic [15:0] vb,
                                          input logic vc);
    return {1'b0, va} + {1'b0, vb} + {16'h0, vc};
  endfunction

  initial begin
    logic [15:0] ra, rb;
    logic        rc, rr;
    rst = 1'b1; a = '0; b = '0; ci = 1'b0;

    // Reset holds outputs at zero despite all-ones inputs
    step("rst0", 1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 17'h00000);
    step("rst1", 1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 17'h00000);
    step("rel",  1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF);

    step("zero",  1'b0, 16'h0000, 16'h0000, 1'b0, 17'h00000);
    step("small", 1'b0, 16'h0001, 16'h0002, 1'b1, 17'h00004);
    step("c4d5",  1'b0, 16'h00C4, 16'h00D5, 1'b0, 17'h00199);
    step("fprop", 1'b0, 16'hFFFF, 16'h0000, 1'b1, 17'h10000);
    step("0fff",  1'b0, 16'h0FFF, 16'h987E, 1'b0, 17'h0A87D);
    step("co1",   1'b0, 16'h895E, 16'h7925, 1'b1, 17'h10284);
    step("co2",   1'b0, 16'hE474, 16'h2857, 1'b0, 17'h10CCB);
    step("co3",   1'b0, 16'hD529, 16'hA82E, 1'b1, 17'h17D58);
    step("bbbb",  1'b0, 16'hBBBB, 16'hBBBB, 1'b1, 17'h17777);
    step("fpropB",1'b0, 16'h0000, 16'hFFFF, 1'b1, 17'h10000);
    step("fprop0",1'b0, 16'hAAAA, 16'h5555, 1'b0, 17'h0FFFF);

    // Back-to-back vectors with a single mid-sequence reset edge
    for (int i = 0; i < 36; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      rr = (i == 18);
      step(rr ? "b2b_rst" : "b2b", rr, ra, rb, rc, rr ? 17'h00000 : ref_add(ra, rb, rc));
    end

    for (int i = 0; i < 10000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      step("rand", 1'b0, ra, rb, rc, ref_add(ra, rb, rc));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
